// File: rtl/spi_ram_pkg.sv
// Shared definitions for the SPI-RAM arbiter: RAM command codes, the sequencer
// state encoding and the 10-bit command word packer.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR    = 3'd1,
        DATA    = 3'd2,
        WAIT_RD = 3'd3,
        DONE    = 3'd4
    } state_e;

    function automatic logic [9:0] pack_cmd(input logic [1:0] cmd, input logic [7:0] data);
        return {cmd, data};
    endfunction

endpackage

// File: rtl/spi_ram_arbiter_rr.sv
// Combinational round-robin picker: first set request at or after ptr,
// searching cyclically; returns a one-hot grant and its index.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W:0]   pos;
    logic [IDX_W-1:0] pos_lo;
    logic             found;

    always_comb begin
        gnt    = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = '0;
        pos_lo = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // ptr + i can exceed NUM_REQ-1 by at most one wrap
            pos = {1'b0, ptr} + (IDX_W+1)'(i);
            if (pos >= (IDX_W+1)'(NUM_REQ)) begin
                pos = pos - (IDX_W+1)'(NUM_REQ);
            end
            pos_lo = pos[IDX_W-1:0];
            if (!found && req[pos_lo]) begin
                found       = 1'b1;
                idx         = pos_lo;
                gnt[pos_lo] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares one SPI-slave RAM among NUM_REQ requesters: round-robin grant, then
// a two-word command sequence per byte access, with a bounded read wait.
module spi_ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int RD_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   req_we,
    input  logic [NUM_REQ*8-1:0] req_addr,
    input  logic [NUM_REQ*8-1:0] req_wdata,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic [7:0]           rdata,
    output logic                 err,
    output logic                 busy,
    output logic [9:0]           ram_din,
    output logic                 ram_rx_valid,
    input  logic [7:0]           ram_dout,
    input  logic                 ram_tx_valid
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 we_q, we_d;
    logic [7:0]           addr_q, addr_d;
    logic [7:0]           wdata_q, wdata_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_flag_q, err_flag_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [7:0]           rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic [9:0]           ram_din_q, ram_din_d;
    logic                 ram_rx_valid_q, ram_rx_valid_d;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [IDX_W-1:0]     arb_idx;
    logic                 sel_we;
    logic [7:0]           sel_addr;
    logic [7:0]           sel_wdata;
    logic                 rd_timeout;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req (req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == IDX_W'(i)) begin
                sel_we    = req_we[i];
                sel_addr  = req_addr[8*i +: 8];
                sel_wdata = req_wdata[8*i +: 8];
            end
        end
    end

    assign rd_timeout = (cnt_q == CNT_W'(RD_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            idx_q          <= '0;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            cnt_q          <= '0;
            err_flag_q     <= 1'b0;
            gnt_q          <= '0;
            done_q         <= '0;
            rdata_q        <= '0;
            err_q          <= 1'b0;
            busy_q         <= 1'b0;
            ram_din_q      <= '0;
            ram_rx_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            idx_q          <= idx_d;
            we_q           <= we_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            cnt_q          <= cnt_d;
            err_flag_q     <= err_flag_d;
            gnt_q          <= gnt_d;
            done_q         <= done_d;
            rdata_q        <= rdata_d;
            err_q          <= err_d;
            busy_q         <= busy_d;
            ram_din_q      <= ram_din_d;
            ram_rx_valid_q <= ram_rx_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = ADDR;
            ADDR:    state_d = DATA;
            DATA:    state_d = we_q ? DONE : WAIT_RD;
            WAIT_RD: if (ram_tx_valid || rd_timeout) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every output is the registered action of the current state, so each
    // step of a transaction becomes visible one cycle after its state.
    always_comb begin
        ptr_d          = ptr_q;
        idx_d          = idx_q;
        we_d           = we_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        cnt_d          = cnt_q;
        err_flag_d     = err_flag_q;
        gnt_d          = '0;
        done_d         = '0;
        rdata_d        = rdata_q;
        err_d          = 1'b0;
        busy_d         = (state_d != IDLE);
        ram_din_d      = ram_din_q;
        ram_rx_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_d      = arb_gnt;
                    idx_d      = arb_idx;
                    we_d       = sel_we;
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
                    err_flag_d = 1'b0;
                end
            end
            ADDR: begin
                ram_rx_valid_d = 1'b1;
                ram_din_d      = pack_cmd(we_q ? CMD_WR_ADDR : CMD_RD_ADDR, addr_q);
            end
            DATA: begin
                ram_rx_valid_d = 1'b1;
                ram_din_d      = we_q ? pack_cmd(CMD_WR_DATA, wdata_q)
                                      : pack_cmd(CMD_RD_DATA, 8'h00);
                if (!we_q) cnt_d = '0;
            end
            WAIT_RD: begin
                cnt_d = cnt_q + 1'b1;
                // A response arriving on the last allowed cycle still counts.
                if (ram_tx_valid) begin
                    rdata_d = ram_dout;
                end else if (rd_timeout) begin
                    rdata_d    = 8'h00;
                    err_flag_d = 1'b1;
                end
            end
            DONE: begin
                done_d[idx_q] = 1'b1;
                err_d         = err_flag_q;
                ptr_d         = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
            end
            default: ;
        endcase
    end

    assign gnt          = gnt_q;
    assign done         = done_q;
    assign rdata        = rdata_q;
    assign err          = err_q;
    assign busy         = busy_q;
    assign ram_din      = ram_din_q;
    assign ram_rx_valid = ram_rx_valid_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed bench for spi_ram_arbiter (2 requesters, read timeout 15).
// Cycle 0 of a transaction is the cycle in which gnt is observed high.
module tb_spi_ram_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [7:0]  rdata;
    logic        err;
    logic        busy;
    logic [9:0]  ram_din;
    logic        ram_rx_valid;
    logic [7:0]  ram_dout;
    logic        ram_tx_valid;

    int checks = 0;
    int fails  = 0;

    spi_ram_arbiter #(.NUM_REQ(2), .RD_TIMEOUT(15)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .done         (done),
        .rdata        (rdata),
        .err          (err),
        .busy         (busy),
        .ram_din      (ram_din),
        .ram_rx_valid (ram_rx_valid),
        .ram_dout     (ram_dout),
        .ram_tx_valid (ram_tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 2'b11; req_we = 2'b11; req_addr = 16'h3377; req_wdata = 16'h99AA;
        ram_dout = 8'hEE; ram_tx_valid = 1'b1;
        repeat (3) step();
        checks++; if (gnt !== 2'b00) begin fails++; $display("FAIL rst_gnt: got %b exp 00", gnt); end
        checks++; if (done !== 2'b00) begin fails++; $display("FAIL rst_done: got %b exp 00", done); end
        checks++; if (rdata !== 8'h00) begin fails++; $display("FAIL rst_rdata: got %h exp 00", rdata); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b exp 0", err); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b exp 0", busy); end
        checks++; if (ram_din !== 10'h000) begin fails++; $display("FAIL rst_din: got %h exp 000", ram_din); end
        checks++; if (ram_rx_valid !== 1'b0) begin fails++; $display("FAIL rst_rxv: got %b exp 0", ram_rx_valid); end
        req = 2'b00; ram_tx_valid = 1'b0; ram_dout = 8'h00;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write();
        req = 2'b01; req_we = 2'b01; req_addr = 16'h0012; req_wdata = 16'h00A5;
        step();
        checks++; if (gnt !== 2'b01) begin fails++; $display("FAIL wr_gnt: got %b exp 01", gnt); end
        req = 2'b00;
        step();
        checks++; if (ram_din !== 10'h012) begin fails++; $display("FAIL wr_din_addr: got %h exp 012", ram_din); end
        checks++; if (ram_rx_valid !== 1'b1) begin fails++; $display("FAIL wr_rxv1: got %b exp 1", ram_rx_valid); end
        step();
        checks++; if (ram_din !== 10'h1A5) begin fails++; $display("FAIL wr_din_data: got %h exp 1a5", ram_din); end
        checks++; if (ram_rx_valid !== 1'b1) begin fails++; $display("FAIL wr_rxv2: got %b exp 1", ram_rx_valid); end
        checks++; if (done !== 2'b00) begin fails++; $display("FAIL wr_done_early: got %b exp 00", done); end
        step();
        checks++; if (done !== 2'b01) begin fails++; $display("FAIL wr_done: got %b exp 01", done); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL wr_err: got %b exp 0", err); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL wr_busy_idle: got %b exp 0", busy); end
    endtask

    task automatic test_timeout();
        int first_done;
        int err_pulses;
        logic [1:0] got_done;
        logic       got_err;
        logic [7:0] got_rdata;
        first_done = -1; err_pulses = 0; got_done = '0; got_err = 1'b0; got_rdata = 8'hXX;
        req = 2'b01; req_we = 2'b00; req_addr = 16'h0040;
        step();
        checks++; if (gnt !== 2'b01) begin fails++; $display("FAIL to_gnt: got %b exp 01", gnt); end
        req = 2'b00;
        for (int k = 1; k <= 25; k++) begin
            step();
            if (err === 1'b1) err_pulses++;
            if (done !== 2'b00 && first_done < 0) begin
                first_done = k; got_done = done; got_err = err; got_rdata = rdata;
            end
        end
        // rx_valid drops in cycle 3; the wait gives up 15 cycles later
        checks++; if (first_done != 18) begin fails++; $display("FAIL to_latency: got %0d exp 18", first_done); end
        checks++; if (got_done !== 2'b01) begin fails++; $display("FAIL to_done: got %b exp 01", got_done); end
        checks++; if (got_err !== 1'b1) begin fails++; $display("FAIL to_err: got %b exp 1", got_err); end
        checks++; if (got_rdata !== 8'h00) begin fails++; $display("FAIL to_rdata: got %h exp 00", got_rdata); end
        checks++; if (err_pulses != 1) begin fails++; $display("FAIL to_err_pulses: got %0d exp 1", err_pulses); end
    endtask

    task automatic test_read();
        req = 2'b10; req_we = 2'b00; req_addr = 16'h3400;
        step();
        checks++; if (gnt !== 2'b10) begin fails++; $display("FAIL rd_gnt: got %b exp 10", gnt); end
        req = 2'b00;
        step();
        checks++; if (ram_din !== 10'h234) begin fails++; $display("FAIL rd_din_addr: got %h exp 234", ram_din); end
        step();
        checks++; if (ram_din !== 10'h300) begin fails++; $display("FAIL rd_din_cmd: got %h exp 300", ram_din); end
        checks++; if (ram_rx_valid !== 1'b1) begin fails++; $display("FAIL rd_rxv: got %b exp 1", ram_rx_valid); end
        step();
        checks++; if (ram_rx_valid !== 1'b0) begin fails++; $display("FAIL rd_rxv_wait: got %b exp 0", ram_rx_valid); end
        checks++; if (ram_din !== 10'h300) begin fails++; $display("FAIL rd_din_hold: got %h exp 300", ram_din); end
        step();
        step();
        ram_tx_valid = 1'b1; ram_dout = 8'h5A;
        step();
        ram_tx_valid = 1'b0; ram_dout = 8'h00;
        checks++; if (rdata !== 8'h5A) begin fails++; $display("FAIL rd_rdata: got %h exp 5a", rdata); end
        checks++; if (done !== 2'b00) begin fails++; $display("FAIL rd_done_early: got %b exp 00", done); end
        step();
        checks++; if (done !== 2'b10) begin fails++; $display("FAIL rd_done: got %b exp 10", done); end
        checks++; if (rdata !== 8'h5A) begin fails++; $display("FAIL rd_rdata_done: got %h exp 5a", rdata); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL rd_err: got %b exp 0", err); end
    endtask

    task automatic test_spurious();
        ram_tx_valid = 1'b1; ram_dout = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (done !== 2'b00) begin fails++; $display("FAIL sp_done: got %b exp 00", done); end
            checks++; if (rdata !== 8'h5A) begin fails++; $display("FAIL sp_rdata: got %h exp 5a", rdata); end
            checks++; if (busy !== 1'b0) begin fails++; $display("FAIL sp_busy: got %b exp 0", busy); end
        end
        ram_tx_valid = 1'b0; ram_dout = 8'h00;
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_g;
        logic [1:0] exp_d;
        logic       exp_b;
        logic [9:0] exp_din;
        req = 2'b11; req_we = 2'b11; req_addr = 16'h2120; req_wdata = 16'hB1B0;
        for (int k = 0; k < 12; k++) begin
            step();
            case (k)
                0: exp_g = 2'b01;
                4: exp_g = 2'b10;
                8: exp_g = 2'b01;
                default: exp_g = 2'b00;
            endcase
            case (k)
                3:  exp_d = 2'b01;
                7:  exp_d = 2'b10;
                11: exp_d = 2'b01;
                default: exp_d = 2'b00;
            endcase
            exp_b = (k % 4) != 3;
            checks++; if (gnt !== exp_g) begin fails++; $display("FAIL b2b_gnt k=%0d: got %b exp %b", k, gnt, exp_g); end
            checks++; if (done !== exp_d) begin fails++; $display("FAIL b2b_done k=%0d: got %b exp %b", k, done, exp_d); end
            checks++; if (busy !== exp_b) begin fails++; $display("FAIL b2b_busy k=%0d: got %b exp %b", k, busy, exp_b); end
            if ((k % 4) == 1 || (k % 4) == 2) begin
                case (k)
                    1: exp_din = 10'h020;
                    2: exp_din = 10'h1B0;
                    5: exp_din = 10'h021;
                    6: exp_din = 10'h1B1;
                    9: exp_din = 10'h020;
                    default: exp_din = 10'h1B0;
                endcase
                checks++; if (ram_din !== exp_din) begin fails++; $display("FAIL b2b_din k=%0d: got %h exp %h", k, ram_din, exp_din); end
            end
            if (k == 8) req = 2'b00;
        end
        checks++; if (rdata !== 8'h5A) begin fails++; $display("FAIL b2b_rdata_hold: got %h exp 5a", rdata); end
    endtask

    task automatic test_abort();
        req = 2'b10; req_we = 2'b00; req_addr = 16'h5500;
        step();
        checks++; if (gnt !== 2'b10) begin fails++; $display("FAIL ab_gnt: got %b exp 10", gnt); end
        req = 2'b00;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        checks++; if (gnt !== 2'b00) begin fails++; $display("FAIL ab_gnt0: got %b exp 00", gnt); end
        checks++; if (done !== 2'b00) begin fails++; $display("FAIL ab_done0: got %b exp 00", done); end
        checks++; if (rdata !== 8'h00) begin fails++; $display("FAIL ab_rdata0: got %h exp 00", rdata); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL ab_err0: got %b exp 0", err); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL ab_busy0: got %b exp 0", busy); end
        checks++; if (ram_din !== 10'h000) begin fails++; $display("FAIL ab_din0: got %h exp 000", ram_din); end
        checks++; if (ram_rx_valid !== 1'b0) begin fails++; $display("FAIL ab_rxv0: got %b exp 0", ram_rx_valid); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (done !== 2'b00) begin fails++; $display("FAIL ab_done_rst: got %b exp 00", done); end
        end
        rst_n = 1'b1;
        step();
        req = 2'b11; req_we = 2'b11; req_addr = 16'h0102; req_wdata = 16'h0304;
        step();
        checks++; if (gnt !== 2'b01) begin fails++; $display("FAIL ab_regrant: got %b exp 01", gnt); end
        req = 2'b00;
        repeat (3) step();
        checks++; if (done !== 2'b01) begin fails++; $display("FAIL ab_done_after: got %b exp 01", done); end
        step();
    endtask

    initial begin
        test_reset();
        test_write();
        test_timeout();
        test_read();
        test_spurious();
        test_back_to_back();
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
